// File: rtl/trap_cmt_arb_if.sv
// Trap-commit arbiter bus: trap sources on one side, CSR update record on the
// other, plus debug/mret controls and the nesting status outputs.
interface trap_cmt_arb_if #(
   parameter int XLEN     = 32,
   parameter int PC_SIZE  = 32,
   parameter int NCH      = 2,
   parameter int NEST_MAX = 2
);
   localparam int CW = $clog2(NEST_MAX + 1);

   logic                    dbg_mode;
   logic [NCH-1:0]          req_vld;
   logic [NCH-1:0]          req_is_irq;
   logic [NCH*XLEN-1:0]     req_cause;
   logic [NCH*PC_SIZE-1:0]  req_epc;
   logic [NCH*XLEN-1:0]     req_tval;
   logic [NCH-1:0]          req_rdy;
   logic                    flush_req;
   logic                    mret_i;
   logic                    cmt_vld;
   logic                    cmt_rdy;
   logic [XLEN-1:0]         cmt_cause;
   logic [PC_SIZE-1:0]      cmt_epc;
   logic [XLEN-1:0]         cmt_tval;
   logic                    cmt_tval_ena;
   logic                    cmt_status_ena;
   logic [CW-1:0]           nest_cnt;
   logic                    lockup;

   // arbiter view
   modport slave (
      input  dbg_mode, req_vld, req_is_irq, req_cause, req_epc, req_tval,
             mret_i, cmt_rdy,
      output req_rdy, flush_req, cmt_vld, cmt_cause, cmt_epc, cmt_tval,
             cmt_tval_ena, cmt_status_ena, nest_cnt, lockup
   );

   // trap sources / CSR file view
   modport master (
      output dbg_mode, req_vld, req_is_irq, req_cause, req_epc, req_tval,
             mret_i, cmt_rdy,
      input  req_rdy, flush_req, cmt_vld, cmt_cause, cmt_epc, cmt_tval,
             cmt_tval_ena, cmt_status_ena, nest_cnt, lockup
   );
endinterface

// File: rtl/trap_cmt_arb.sv
// Trap-commit arbiter: fixed-priority pick among NCH trap requests, one
// registered CSR update record held over a valid/ready handshake, trap
// nesting depth tracking against mret, sticky lockup on nesting overflow.
module trap_cmt_arb #(
   parameter int XLEN     = 32,
   parameter int PC_SIZE  = 32,
   parameter int NCH      = 2,
   parameter int NEST_MAX = 2
) (
   input  logic           clk,
   input  logic           rst,
   trap_cmt_arb_if.slave  bus
);
   localparam int CW = $clog2(NEST_MAX + 1);
   localparam logic [CW-1:0] NEST_TOP = CW'(NEST_MAX);

   typedef enum logic {IDLE, HOLD} state_t;

   typedef struct packed {
      logic [XLEN-1:0]    cause;
      logic [PC_SIZE-1:0] epc;
      logic [XLEN-1:0]    tval;
      logic               is_irq;
   } rec_t;

   state_t        state_q, state_d;
   rec_t          rec_q, rec_d;
   logic [CW-1:0] nest_q, nest_d;
   logic          lockup_q, lockup_d;

   logic [NCH-1:0] elig;
   logic [NCH-1:0] gnt;
   logic           any_gnt;
   logic           exc_pend;
   logic           ovf;
   logic           hs;
   logic           dec;

   // Per-channel eligibility. Interrupts wait until no trap is active; an
   // exception at full nesting depth is never granted (it trips lockup).
   for (genvar g = 0; g < NCH; g++) begin : g_elig
      assign elig[g] = bus.req_vld[g] & ~bus.dbg_mode & ~lockup_q &
                       (bus.req_is_irq[g] ? (nest_q == '0) : (nest_q != NEST_TOP));
   end

   assign exc_pend = |(bus.req_vld & ~bus.req_is_irq);
   assign ovf      = (state_q == IDLE) & ~bus.dbg_mode & ~lockup_q & exc_pend &
                     (nest_q == NEST_TOP);
   assign hs       = (state_q == HOLD) & bus.cmt_rdy;
   assign dec      = bus.mret_i & (nest_q != '0);

   // Grant the lowest eligible channel in IDLE and capture its record
   always_comb begin
      gnt     = '0;
      any_gnt = 1'b0;
      rec_d   = rec_q;
      state_d = state_q;
      if (state_q == IDLE) begin
         for (int i = 0; i < NCH; i++) begin
            if (elig[i] && !any_gnt) begin
               gnt[i]       = 1'b1;
               any_gnt      = 1'b1;
               rec_d.cause  = bus.req_cause[i*XLEN +: XLEN];
               rec_d.epc    = bus.req_epc[i*PC_SIZE +: PC_SIZE];
               rec_d.tval   = bus.req_tval[i*XLEN +: XLEN];
               rec_d.is_irq = bus.req_is_irq[i];
            end
         end
         if (any_gnt) state_d = HOLD;
      end else if (hs) begin
         state_d = IDLE;
      end
   end

   // Nesting depth: +1 on handshake, -1 on mret, both together cancel
   always_comb begin
      nest_d = nest_q;
      if (hs && !bus.mret_i) begin
         if (nest_q != NEST_TOP) nest_d = nest_q + 1'b1;
      end else if (dec && !hs) begin
         nest_d = nest_q - 1'b1;
      end
   end

   // Lockup is sticky until reset
   always_comb begin
      lockup_d = lockup_q | ovf;
   end

   // State, record, depth and lockup registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rec_q    <= '0;
         nest_q   <= '0;
         lockup_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rec_q    <= rec_d;
         nest_q   <= nest_d;
         lockup_q <= lockup_d;
      end
   end

   assign bus.req_rdy        = gnt;
   assign bus.flush_req      = any_gnt;
   assign bus.cmt_vld        = (state_q == HOLD);
   assign bus.cmt_cause      = rec_q.cause;
   assign bus.cmt_epc        = rec_q.epc;
   assign bus.cmt_tval       = rec_q.is_irq ? '0 : rec_q.tval;
   assign bus.cmt_tval_ena   = (state_q == HOLD) & ~rec_q.is_irq;
   assign bus.cmt_status_ena = (state_q == HOLD);
   assign bus.nest_cnt       = nest_q;
   assign bus.lockup         = lockup_q;
endmodule

// File: tb/tb_trap_cmt_arb.sv
// Directed bench for trap_cmt_arb (NCH=2, NEST_MAX=2).
module tb_trap_cmt_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   trap_cmt_arb_if #(.XLEN(32), .PC_SIZE(32), .NCH(2), .NEST_MAX(2)) bus ();

   trap_cmt_arb #(.XLEN(32), .PC_SIZE(32), .NCH(2), .NEST_MAX(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input logic v, input logic irq,
                         input logic [31:0] c, input logic [31:0] e, input logic [31:0] t);
      bus.req_vld[i]             = v;
      bus.req_is_irq[i]          = irq;
      bus.req_cause[i*32 +: 32]  = c;
      bus.req_epc[i*32 +: 32]    = e;
      bus.req_tval[i*32 +: 32]   = t;
   endtask

   initial begin
      bus.dbg_mode  = 1'b0;
      bus.req_vld   = '0;
      bus.req_is_irq = '0;
      bus.req_cause = '0;
      bus.req_epc   = '0;
      bus.req_tval  = '0;
      bus.mret_i    = 1'b0;
      bus.cmt_rdy   = 1'b0;
      tick(); tick();
      #1;
      chk("rst_vld",    bus.cmt_vld, 0);
      chk("rst_nest",   bus.nest_cnt, 0);
      chk("rst_lockup", bus.lockup, 0);
      chk("rst_cause",  bus.cmt_cause, 0);
      chk("rst_epc",    bus.cmt_epc, 0);
      chk("rst_tval",   bus.cmt_tval, 0);
      chk("rst_tvena",  bus.cmt_tval_ena, 0);
      chk("rst_stena",  bus.cmt_status_ena, 0);
      chk("rst_rdy",    bus.req_rdy, 0);
      chk("rst_flush",  bus.flush_req, 0);
      rst = 1'b0;

      // basic exception on ch0
      tick();
      set_ch(0, 1, 0, 32'h2, 32'h100, 32'hDEAD);
      bus.cmt_rdy = 1'b1;
      #1;
      chk("b_rdy",   bus.req_rdy, 2'b01);
      chk("b_flush", bus.flush_req, 1);
      tick();
      set_ch(0, 0, 0, 0, 0, 0);
      #1;
      chk("b_vld",   bus.cmt_vld, 1);
      chk("b_cause", bus.cmt_cause, 32'h2);
      chk("b_epc",   bus.cmt_epc, 32'h100);
      chk("b_tval",  bus.cmt_tval, 32'hDEAD);
      chk("b_tvena", bus.cmt_tval_ena, 1);
      chk("b_stena", bus.cmt_status_ena, 1);
      chk("b_nest1", bus.nest_cnt, 0);
      tick();
      chk("b_vld_off", bus.cmt_vld, 0);
      chk("b_nest",    bus.nest_cnt, 1);

      // interrupt masked while a trap is active
      set_ch(1, 1, 1, 32'h8000000B, 32'h200, 32'h55);
      #1;
      chk("m_rdy0", bus.req_rdy, 2'b00);
      tick();
      chk("m_rdy1", bus.req_rdy, 2'b00);
      chk("m_vld",  bus.cmt_vld, 0);
      bus.mret_i = 1'b1;
      #1;
      chk("m_rdy2", bus.req_rdy, 2'b00);
      tick();
      bus.mret_i  = 1'b0;
      bus.cmt_rdy = 1'b0;
      #1;
      chk("m_nest0", bus.nest_cnt, 0);
      chk("m_rdy",   bus.req_rdy, 2'b10);
      chk("m_flush", bus.flush_req, 1);
      tick();
      set_ch(1, 0, 0, 0, 0, 0);
      #1;
      chk("m_vld1",  bus.cmt_vld, 1);
      chk("m_cause", bus.cmt_cause, 32'h8000000B);
      chk("m_epc",   bus.cmt_epc, 32'h200);
      chk("m_tval",  bus.cmt_tval, 0);
      chk("m_tvena", bus.cmt_tval_ena, 0);
      bus.cmt_rdy = 1'b1;
      tick();
      chk("m_done", bus.cmt_vld, 0);
      chk("m_nest", bus.nest_cnt, 1);

      // mret on the handshake cycle cancels the increment
      set_ch(0, 1, 0, 32'h4, 32'h300, 32'h7);
      #1;
      chk("s_rdy", bus.req_rdy, 2'b01);
      tick();
      set_ch(0, 0, 0, 0, 0, 0);
      bus.mret_i = 1'b1;
      tick();
      bus.mret_i = 1'b0;
      chk("s_vld",  bus.cmt_vld, 0);
      chk("s_nest", bus.nest_cnt, 1);
      bus.mret_i = 1'b1;
      tick();
      chk("s_dec", bus.nest_cnt, 0);
      tick();
      bus.mret_i = 1'b0;
      chk("s_zero", bus.nest_cnt, 0);

      // priority and backpressure
      set_ch(0, 1, 0, 32'h5, 32'h400, 32'h11);
      set_ch(1, 1, 0, 32'h6, 32'h500, 32'h22);
      bus.cmt_rdy = 1'b0;
      #1;
      chk("p_rdy", bus.req_rdy, 2'b01);
      tick();
      set_ch(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("p_hvld",   bus.cmt_vld, 1);
         chk("p_hcause", bus.cmt_cause, 32'h5);
         chk("p_hepc",   bus.cmt_epc, 32'h400);
         chk("p_hrdy",   bus.req_rdy, 2'b00);
         tick();
      end
      bus.cmt_rdy = 1'b1;
      #1;
      chk("p_hs_vld", bus.cmt_vld, 1);
      chk("p_hs_rdy", bus.req_rdy, 2'b00);
      chk("p_hs_fl",  bus.flush_req, 0);
      tick();
      chk("p_rdy1",  bus.req_rdy, 2'b10);
      chk("p_nest1", bus.nest_cnt, 1);
      tick();
      set_ch(1, 0, 0, 0, 0, 0);
      #1;
      chk("p_cause1", bus.cmt_cause, 32'h6);
      chk("p_epc1",   bus.cmt_epc, 32'h500);
      chk("p_tval1",  bus.cmt_tval, 32'h22);
      tick();
      chk("p_nest2", bus.nest_cnt, 2);

      // nesting overflow -> lockup
      set_ch(0, 1, 0, 32'h7, 32'h600, 32'h33);
      #1;
      chk("l_rdy",  bus.req_rdy, 2'b00);
      chk("l_lock0", bus.lockup, 0);
      tick();
      set_ch(0, 0, 0, 0, 0, 0);
      chk("l_lock1", bus.lockup, 1);
      chk("l_vld",   bus.cmt_vld, 0);
      bus.mret_i = 1'b1;
      tick();
      bus.mret_i = 1'b0;
      set_ch(0, 1, 0, 32'h8, 32'h700, 32'h44);
      #1;
      chk("l_nest", bus.nest_cnt, 1);
      chk("l_rdy2", bus.req_rdy, 2'b00);
      chk("l_hold", bus.lockup, 1);
      tick();
      chk("l_hold2", bus.lockup, 1);
      set_ch(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("r_lock", bus.lockup, 0);
      chk("r_nest", bus.nest_cnt, 0);

      // debug mode blocks grants
      bus.dbg_mode = 1'b1;
      set_ch(0, 1, 0, 32'h9, 32'h800, 32'h66);
      set_ch(1, 1, 0, 32'hA, 32'h900, 32'h77);
      #1;
      chk("d_rdy",   bus.req_rdy, 2'b00);
      chk("d_flush", bus.flush_req, 0);
      tick();
      bus.dbg_mode = 1'b0;
      bus.cmt_rdy  = 1'b0;
      #1;
      chk("d_rdy1", bus.req_rdy, 2'b01);
      tick();
      set_ch(0, 0, 0, 0, 0, 0);
      set_ch(1, 0, 0, 0, 0, 0);
      bus.dbg_mode = 1'b1;
      tick();
      chk("d_hvld",  bus.cmt_vld, 1);
      chk("d_hcause", bus.cmt_cause, 32'h9);
      bus.cmt_rdy = 1'b1;
      tick();
      bus.dbg_mode = 1'b0;
      chk("d_done", bus.cmt_vld, 0);
      chk("d_nest", bus.nest_cnt, 1);

      // reset while holding a record
      set_ch(0, 1, 0, 32'hB, 32'hA00, 32'h88);
      bus.cmt_rdy = 1'b0;
      tick();
      set_ch(0, 0, 0, 0, 0, 0);
      chk("r_hvld", bus.cmt_vld, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("r_vld",   bus.cmt_vld, 0);
      chk("r_nest0", bus.nest_cnt, 0);
      chk("r_cause", bus.cmt_cause, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
